// File: rtl/jk_counter_pkg.sv
// ============================================================================
// jk_counter_pkg : {J,K} op encodings shared by the JK-style mod-N counters.
// Revision 1.0
// ============================================================================
`default_nettype none

package jk_counter_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_CLR  = 2'b01,
    OP_LOAD = 2'b10,
    OP_CNT  = 2'b11
  } op_e;

endpackage : jk_counter_pkg

`default_nettype wire

// File: rtl/jk_mod_counter.sv
// ============================================================================
// jk_mod_counter : WIDTH-bit mod-MODULUS counter driven by per-cycle {J,K} ops.
// Revision 1.0
// ============================================================================
`default_nettype none

module jk_mod_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             Clk,
  input  logic             clear,
  input  logic             ce,
  input  logic             J,
  input  logic             K,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Qout,
  output logic             tc,
  output logic             wrap_flag,
  output logic             load_err
);

  // Top of the count range; fits in WIDTH bits even when MODULUS == 2**WIDTH.
  localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  op_e              op;
  logic [WIDTH+1:0] nxt;

  // Packs {wrap, load_err, next_q}; comparing against TERM_UP avoids overflow.
  function automatic logic [WIDTH+1:0] next_val(
    input op_e              cur_op,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] d,
    input logic             up
  );
    logic [WIDTH-1:0] nq;
    logic             wrap;
    logic             err;
    nq   = q;
    wrap = 1'b0;
    err  = 1'b0;
    case (cur_op)
      OP_HOLD: nq = q;
      OP_CLR:  nq = '0;
      OP_LOAD: begin
        if (d > TERM_UP) begin
          nq  = TERM_UP;
          err = 1'b1;
        end else begin
          nq = d;
        end
      end
      OP_CNT: begin
        if (up) begin
          if (q >= TERM_UP) begin
            nq   = '0;
            wrap = 1'b1;
          end else begin
            nq = q + ONE;
          end
        end else begin
          if (q == '0) begin
            nq   = TERM_UP;
            wrap = 1'b1;
          end else begin
            nq = q - ONE;
          end
        end
      end
      default: nq = q;
    endcase
    return {wrap, err, nq};
  endfunction

  assign op  = op_e'({J, K});
  assign nxt = next_val(op, Qout, D, up_dn);

  assign tc = ce && (op == OP_CNT) && (Qout == (up_dn ? TERM_UP : '0));

  always_ff @(posedge Clk or negedge clear) begin
    if (!clear) begin
      Qout      <= '0;
      wrap_flag <= 1'b0;
      load_err  <= 1'b0;
    end else if (!ce) begin
      load_err <= 1'b0;
    end else begin
      Qout     <= nxt[WIDTH-1:0];
      load_err <= nxt[WIDTH];
      if (op == OP_CLR)
        wrap_flag <= 1'b0;
      else if (nxt[WIDTH+1])
        wrap_flag <= 1'b1;
    end
  end

endmodule : jk_mod_counter

`default_nettype wire

// File: tb/tb_jk_mod_counter.sv
// ============================================================================
// tb_jk_mod_counter : directed self-checking bench, single and cascaded digits.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_jk_mod_counter;

  logic       clk;
  logic       clear;
  logic       ce, j, k, up_dn;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc, wrap_flag, load_err;

  logic       c_ce, c_j, c_k, c_up, c_load;
  logic [3:0] c_dlo, c_dhi, lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap, lo_err, hi_err, hi_ce;

  int checks = 0;
  int errors = 0;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .Clk(clk), .clear(clear), .ce(ce), .J(j), .K(k), .up_dn(up_dn), .D(d),
    .Qout(q), .tc(tc), .wrap_flag(wrap_flag), .load_err(load_err)
  );

  // High digit advances on the low digit's tc; c_load lets both digits preload.
  assign hi_ce = lo_tc | c_load;

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .Clk(clk), .clear(clear), .ce(c_ce), .J(c_j), .K(c_k), .up_dn(c_up), .D(c_dlo),
    .Qout(lo_q), .tc(lo_tc), .wrap_flag(lo_wrap), .load_err(lo_err)
  );

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .Clk(clk), .clear(clear), .ce(hi_ce), .J(c_j), .K(c_k), .up_dn(c_up), .D(c_dhi),
    .Qout(hi_q), .tc(hi_tc), .wrap_flag(hi_wrap), .load_err(hi_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic e, input logic jj, input logic kk, input logic u,
                    input logic [3:0] dv);
    ce = e; j = jj; k = kk; up_dn = u; d = dv;
  endtask

  initial begin
    clear = 1'b0;
    op(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    c_ce = 1'b0; c_j = 1'b0; c_k = 1'b0; c_up = 1'b1; c_load = 1'b0;
    c_dlo = 4'd0; c_dhi = 4'd0;
    #12;
    chk("reset_q", q, 0);
    chk("reset_wrap", wrap_flag, 0);
    chk("reset_err", load_err, 0);
    chk("reset_tc", tc, 0);
    clear = 1'b1;
    step();

    // Count up through the full range and wrap.
    op(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    #1;
    chk("up_tc0", tc, 0);
    for (int i = 1; i <= 9; i++) begin
      step();
      chk("up_q", q, 8'(i));
      chk("up_tc", tc, (i == 9) ? 8'd1 : 8'd0);
      chk("up_wrap_pre", wrap_flag, 0);
    end
    step();
    chk("up_wrap_q", q, 0);
    chk("up_wrap_flag", wrap_flag, 1);
    chk("up_wrap_tc", tc, 0);

    // Sync clear, then count down from 0.
    op(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
    step();
    chk("clr_q", q, 0);
    chk("clr_wrap", wrap_flag, 0);
    op(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    #1;
    chk("dn_tc_at0", tc, 1);
    up_dn = 1'b1;
    #1;
    chk("retarget_tc", tc, 0);
    up_dn = 1'b0;
    step();
    chk("dn_wrap_q", q, 9);
    chk("dn_wrap_flag", wrap_flag, 1);
    chk("dn_tc_at9", tc, 0);
    step();
    chk("dn_q8", q, 8);

    // Loads: in range, out of range, then the error pulse clears.
    op(1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
    step();
    chk("load5_q", q, 5);
    chk("load5_err", load_err, 0);
    d = 4'd12;
    step();
    chk("load12_q", q, 9);
    chk("load12_err", load_err, 1);
    op(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    step();
    chk("hold_q", q, 9);
    chk("hold_err", load_err, 0);
    op(1'b1, 1'b1, 1'b0, 1'b1, 4'd15);
    step();
    chk("load15_err", load_err, 1);
    ce = 1'b0;
    step();
    chk("ce0_err", load_err, 0);
    chk("ce0_q", q, 9);

    // ce gating of sync clear; wrap_flag still set from the down wrap.
    op(1'b1, 1'b1, 1'b0, 1'b1, 4'd7);
    step();
    chk("load7_q", q, 7);
    op(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    step();
    chk("ce0clr_q", q, 7);
    chk("ce0clr_wrap", wrap_flag, 1);
    chk("ce0clr_tc", tc, 0);
    ce = 1'b1;
    step();
    chk("ce1clr_q", q, 0);
    chk("ce1clr_wrap", wrap_flag, 0);

    // Async reset mid-cycle.
    op(1'b1, 1'b1, 1'b0, 1'b1, 4'd9);
    step();
    op(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    step();
    chk("pre_rst_wrap", wrap_flag, 1);
    op(1'b1, 1'b1, 1'b0, 1'b1, 4'd7);
    step();
    op(1'b1, 1'b1, 1'b1, 1'b1, 4'd0);
    chk("pre_rst_q", q, 7);
    #2;
    clear = 1'b0;
    #1;
    chk("async_q", q, 0);
    chk("async_wrap", wrap_flag, 0);
    chk("async_tc", tc, 0);
    #2;
    clear = 1'b1;
    step();
    chk("resume_q", q, 1);

    // Two-digit cascade: 98 -> 99 -> 00.
    c_ce = 1'b1; c_j = 1'b1; c_k = 1'b0; c_load = 1'b1; c_dlo = 4'd8; c_dhi = 4'd9;
    step();
    chk("cas_lo98", lo_q, 8);
    chk("cas_hi98", hi_q, 9);
    c_load = 1'b0; c_j = 1'b1; c_k = 1'b1; c_up = 1'b1;
    #1;
    chk("cas_lotc98", lo_tc, 0);
    chk("cas_hitc98", hi_tc, 0);
    step();
    chk("cas_lo99", lo_q, 9);
    chk("cas_hi99", hi_q, 9);
    chk("cas_lotc99", lo_tc, 1);
    chk("cas_hitc99", hi_tc, 1);
    step();
    chk("cas_lo00", lo_q, 0);
    chk("cas_hi00", hi_q, 0);
    chk("cas_hitc00", hi_tc, 0);
    chk("cas_hiwrap", hi_wrap, 1);
    chk("cas_lowrap", lo_wrap, 1);
    step();
    chk("cas_lo01", lo_q, 1);
    chk("cas_hi01", hi_q, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_jk_mod_counter

`default_nettype wire
